// File: rtl/razor_pkg.sv
// rtl/razor_pkg.sv - shared state encoding and default widths for the razor error controller
package razor_pkg;

  localparam int M_DEF       = 6;
  localparam int NUM_SRC_DEF = 4;
  localparam int WIN_DEF     = 256;
  localparam int THRESH_DEF  = 4;
  localparam int RELAX_DEF   = 8;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } razor_state_e;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

endpackage

// File: rtl/razor_error_ctrl_if.sv
// rtl/razor_error_ctrl_if.sv - beat, status and scaling signals between upstream razor stages and the controller
interface razor_error_ctrl_if
  import razor_pkg::*;
#(
  parameter int M       = M_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int CNT_W   = CNT_W_DEF
);

  logic                         in_valid;
  logic [NUM_SRC-1:0]           err_vec;
  logic [NUM_SRC-1:0][M-1:0]    be_in;
  logic                         clr_stats;
  logic                         out_valid;
  logic [NUM_SRC-1:0][M-1:0]    be_out;
  logic                         stall;
  logic [NUM_SRC-1:0]           err_sticky;
  logic [CNT_W-1:0]             err_count;
  logic                         dvfs_up;
  logic                         dvfs_down;

  modport master (
    output in_valid, err_vec, be_in, clr_stats,
    input  out_valid, be_out, stall, err_sticky, err_count, dvfs_up, dvfs_down
  );

  modport slave (
    input  in_valid, err_vec, be_in, clr_stats,
    output out_valid, be_out, stall, err_sticky, err_count, dvfs_up, dvfs_down
  );

endinterface

// File: rtl/razor_window_monitor.sv
// rtl/razor_window_monitor.sv - per-window error tally and dvfs up/down pulse generation
module razor_window_monitor
  import razor_pkg::*;
#(
  parameter int WIN    = WIN_DEF,
  parameter int THRESH = THRESH_DEF,
  parameter int RELAX  = RELAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic err_event,
  input  logic clr_stats,
  output logic dvfs_up,
  output logic dvfs_down
);

  localparam int WC_W = $clog2(WIN);
  localparam int WE_W = $clog2(THRESH + 1);
  localparam int ST_W = $clog2(RELAX + 1);

  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN - 1);
  localparam logic [WE_W:0]   THR      = (WE_W + 1)'(THRESH);
  localparam logic [ST_W-1:0] RLX      = ST_W'(RELAX);

  logic [WC_W-1:0] win_cnt;
  logic [WE_W-1:0] win_err;
  logic [ST_W-1:0] streak;

  logic [WE_W:0]   err_sum;
  logic [WE_W-1:0] err_sat;
  logic [ST_W-1:0] streak_inc;
  logic            win_end;

  // err_sum includes the current cycle's event so a hit on the last cycle closes into this window
  always_comb begin
    err_sum    = {1'b0, win_err} + (WE_W + 1)'(err_event);
    err_sat    = (err_sum >= THR) ? THR[WE_W-1:0] : err_sum[WE_W-1:0];
    streak_inc = streak + ST_W'(1);
    win_end    = (win_cnt == WIN_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      win_cnt   <= '0;
      win_err   <= '0;
      streak    <= '0;
      dvfs_up   <= 1'b0;
      dvfs_down <= 1'b0;
    end else begin
      dvfs_up   <= 1'b0;
      dvfs_down <= 1'b0;
      win_cnt   <= win_cnt + WC_W'(1);
      if (win_end) begin
        win_err <= '0;
        if (err_sum >= THR) begin
          dvfs_up <= 1'b1;
          streak  <= '0;
        end else if (err_sum == '0) begin
          if (streak_inc == RLX) begin
            dvfs_down <= 1'b1;
            streak    <= '0;
          end else begin
            streak <= streak_inc;
          end
        end else begin
          streak <= '0;
        end
      end else begin
        win_err <= err_sat;
      end
    end
  end

endmodule

// File: rtl/razor_error_ctrl.sv
// rtl/razor_error_ctrl.sv - razor recovery FSM, output staging, error statistics and dvfs request top
module razor_error_ctrl
  import razor_pkg::*;
#(
  parameter int M       = M_DEF,
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int WIN     = WIN_DEF,
  parameter int THRESH  = THRESH_DEF,
  parameter int RELAX   = RELAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  razor_error_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [0:0]                state;
  logic [NUM_SRC-1:0][M-1:0] hold_reg;
  logic                      flagged;
  logic                      err_event;

  assign flagged   = bus.in_valid && (bus.err_vec != '0);
  assign err_event = (state == ST_RUN) && flagged;
  assign bus.stall = (state == ST_RECOVER);

  // RECOVER is a single bubble: upstream holds its registers, so inputs that cycle are not consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      hold_reg      <= '0;
      bus.out_valid <= 1'b0;
      bus.be_out    <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flagged) begin
            state         <= ST_RECOVER;
            hold_reg      <= bus.be_in;
            bus.out_valid <= 1'b0;
          end else if (bus.in_valid) begin
            bus.out_valid <= 1'b1;
            bus.be_out    <= bus.be_in;
          end else begin
            bus.out_valid <= 1'b0;
          end
        end
        default: begin
          state         <= ST_RUN;
          bus.out_valid <= 1'b1;
          bus.be_out    <= hold_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clr_stats) begin
      bus.err_sticky <= '0;
      bus.err_count  <= '0;
    end else if (err_event) begin
      bus.err_sticky <= bus.err_sticky | bus.err_vec;
      if (bus.err_count != CNT_MAX) begin
        bus.err_count <= bus.err_count + CNT_W'(1);
      end
    end
  end

  razor_window_monitor #(
    .WIN    (WIN),
    .THRESH (THRESH),
    .RELAX  (RELAX)
  ) u_window_monitor (
    .clk       (clk),
    .rst       (rst),
    .err_event (err_event),
    .clr_stats (bus.clr_stats),
    .dvfs_up   (bus.dvfs_up),
    .dvfs_down (bus.dvfs_down)
  );

endmodule
